// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: {o_cout, o_sum} = i_a + i_b + i_cin, one bit per cycle.
// Result and o_done appear WIDTH cycles after an accepted start; i_start is ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_busy,
  output logic             o_done
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_c;

  logic             w_ha1_s;
  logic             w_ha1_c;
  logic             w_ha2_s;
  logic             w_ha2_c;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full adder as two cascaded half adders on the current LSBs and the carry flop.
  assign w_ha1_s    = r_a[0] ^ r_b[0];
  assign w_ha1_c    = r_a[0] & r_b[0];
  assign w_ha2_s    = w_ha1_s ^ r_c;
  assign w_ha2_c    = w_ha1_s & r_c;
  assign w_c_next   = w_ha1_c | w_ha2_c;
  assign w_res_next = {w_ha2_s, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_c     <= 1'b0;
      o_sum   <= '0;
      o_cout  <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_c     <= i_cin;
            r_cnt   <= '0;
            o_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + CW'(1);
          // Outputs only move here, so they hold the previous result through any later RUN.
          if (w_last) begin
            o_sum   <= w_res_next;
            o_cout  <= w_c_next;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, bit-serial, LSB-first binary adder. It computes `{cout, sum} = a + b + cin` over `WIDTH` clock cycles, using one full-adder cell built from two half-adder stages plus a carry flip-flop. It is the sequential, width-generic successor to the team's combinational half adder. It targets area-constrained datapaths where a `WIDTH`-bit ripple adder is too large, and it exposes a start/busy/done handshake for a controlling FSM.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  `WIDTH`  operand A; latched on an accepted start.
- `b`  in  `WIDTH`  operand B; latched on an accepted start.
- `cin`  in  1  carry-in; latched on an accepted start.
- `sum`  out  `WIDTH`  result low bits; registered.
- `cout`  out  1  result carry-out; registered.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse, high while in DONE.

## Operation
- **States:** IDLE, RUN, DONE.
- **Accepting a start:** with `start=1` in IDLE or DONE, the edge does all of the following:
  - latches `a` and `b` into shift registers and `cin` into the carry flip-flop;
  - clears the bit counter to 0;
  - moves the FSM to RUN.
- **RUN, each edge:**
  - processes bit i = counter;
  - s_i = a_i ^ b_i ^ c, formed as half adder 1 (a_i, b_i) followed by half adder 2 (HA1 sum, c);
  - c ← HA1 carry | HA2 carry;
  - s_i shifts into the result register from the MSB side;
  - the counter increments.
- **Leaving RUN:** on the edge processing bit `WIDTH`-1:
  - `sum` ← the complete shifted result;
  - `cout` ← final carry;
  - FSM → DONE.
- **DONE:** lasts one cycle. On the next edge the FSM goes to RUN if `start=1`, otherwise to IDLE.
- **`start` in RUN:** ignored. No restart, no queuing.
- **Input changes during RUN:** changes on `a`, `b` and `cin` have no effect. Only the latched copies are used.
- **Output hold:** `sum` and `cout` change only on the completion edge or on reset. They hold the last result through IDLE and through the whole of any following RUN.
- **Arithmetic:**
  - unsigned, modulo 2^(`WIDTH`+1);
  - no saturation and no overflow flag;
  - `cout` is the true carry out of bit `WIDTH`-1.
- **Internal state:** counter width is $clog2(`WIDTH`). Operand and result shift registers are `WIDTH` bits each.

## Timing
- **Reset:** `rst_n=0` at an edge forces:
  - FSM → IDLE;
  - `sum`=0, `cout`=0, `busy`=0, `done`=0;
  - counter = 0, carry = 0, shift registers = 0.
- **Reset priority:** reset overrides `start` and every state, including mid-RUN. An in-flight operation is discarded, and no `done` pulse is produced for it.
- **Latency:**
  - start accepted at edge E0;
  - `busy`=1 after E0;
  - bits are processed at edges E1 … E`WIDTH`;
  - `done`=1, `busy`=0, and the result is valid after E`WIDTH`.
  - `done` therefore rises `WIDTH` cycles after the accepting edge.
- **Throughput:** one result per `WIDTH`+1 cycles when `start` is held high. A start accepted in DONE gives a back-to-back operation with no IDLE cycle.
- **Signal relationships:**
  - `done` is exactly one cycle wide;
  - `busy` and `done` are never high together;
  - in IDLE, both are 0.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Test plan
- **Zero operands.** `WIDTH`=8; `a`=0x00, `b`=0x00, `cin`=0; pulse `start`.
  - Required: `busy`=1 for 8 cycles, then `done` pulses once.
  - Required: `sum`=0x00, `cout`=0.
- **Full carry ripple.** `a`=0xFF, `b`=0x01, `cin`=0.
  - Required: `sum`=0x00, `cout`=1.
  - Then `a`=0xA5, `b`=0x5A, `cin`=1. Required: `sum`=0x00, `cout`=1.
  - Then `a`=0x12, `b`=0x34, `cin`=0. Required: `sum`=0x46, `cout`=0.
- **Input changes and back-to-back.** Start 0x0F + 0x01. On the cycle after acceptance, drive `a`=0xFF with `start` held high.
  - Required: the first result is 0x10, `cout`=0, with no restart during RUN.
  - Required: the second operation (0xFF + 0x01) starts from DONE with no IDLE cycle and yields 0x00, `cout`=1.
  - Required: `done` pulses exactly 9 cycles apart.
- **Reset mid-operation.** Drive `rst_n`=0 for one edge at the 4th RUN cycle of 0x80 + 0x80.
  - Required: next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0, and no `done` pulse follows.
  - Required: a subsequent 0x80 + 0x80 gives `sum`=0x00, `cout`=1.
- **Exhaustive, minimum width.** `WIDTH`=2; all 32 combinations of `a`, `b`, `cin`.
  - Required: `{cout, sum}` equals `a`+`b`+`cin` for every case.
  - Required: `done` arrives exactly 2 cycles after each accept.
  - Required: `sum` and `cout` are stable in IDLE between operations.
